keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Scans a 4x4 matrix keypad, debounces press and release, and drives the `keypad_pressed`/`key[4:0]` level interface consumed by the game state machine.
- Key codes come from matrix position; the game FSM uses 10=PWRB, 13=STB, 14=NO, 15=YES.
- Sits between the board keypad pins and the top-level control logic; one clock domain (27 MHz board clock).

Parameters:
- SCAN_DIV, 27000, clk cycles each column is driven before rows are sampled (1 ms at 27 MHz); min 4.
- DEBOUNCE_CYC, 540000, consecutive stable cycles required to accept a press or a release (20 ms); min 2.

Ports:
- clk  input  1  system clock, 27 MHz.
- rst  input  1  reset, asynchronous, active-high.
- row_n  input  4  keypad rows, active-low (pulled up externally), asynchronous to clk.
- col_n  output  4  keypad column drive, active-low, exactly one bit low at all times.
- keypad_pressed  output  1  high while a debounced key is held.
- key  output  5  code of held key = 4*row+col (0..15); 5'd31 when no key held.
- key_strobe  output  1  one-cycle pulse on the cycle keypad_pressed rises.

Behaviour:
- Reset (async, rst high):
  - col_n=4'b1110 (column 0 active); keypad_pressed=0; key=5'd31; key_strobe=0.
  - State SCAN; all counters 0; synchronizer flops = 4'b1111.
- row_n passes through a 2-flop synchronizer; all decisions use the synchronized value (rows_s).
- Counters: scan counter ceil(log2(SCAN_DIV)) bits; debounce counter ceil(log2(DEBOUNCE_CYC+1)) bits; no wrap beyond terminal count.
- States: SCAN, DEBOUNCE, HELD, RELEASE.
- SCAN:
  - Scan counter counts 0..SCAN_DIV-1; rows_s is sampled only when the count equals SCAN_DIV-1 (settle window).
  - If all rows are high at the sample: rotate the active column 0→1→2→3→0, clear the counter, stay in SCAN.
  - If any row is low: latch cand_row (lowest-index low row) and cand_col (active column), freeze col_n, clear the debounce counter, go to DEBOUNCE.
- DEBOUNCE:
  - Each cycle with rows_s[cand_row]==0 increments the debounce counter.
  - Any cycle with rows_s[cand_row]==1: abort to SCAN, counter cleared, advance to next column, outputs unchanged.
  - When the counter reaches DEBOUNCE_CYC: next cycle key=4*cand_row+cand_col, keypad_pressed=1, key_strobe=1 for that single cycle; go to HELD.
- HELD:
  - Column stays frozen; outputs stable.
  - When rows_s[cand_row]==1: clear the debounce counter, go to RELEASE.
  - Other rows going low are ignored (no rollover; first key wins).
- RELEASE:
  - Each cycle with rows_s[cand_row]==1 increments the counter.
  - Any low sample returns to HELD with the counter cleared (bounce on release); keypad_pressed stays 1 and key_strobe does not re-fire.
  - When the counter reaches DEBOUNCE_CYC: next cycle keypad_pressed=0, key=5'd31; advance to next column; go to SCAN.
- Simultaneous presses in the same column: lowest row index wins. Presses in different columns: whichever column is scanned first wins.
- Latency, press to keypad_pressed: ≤ 2 (sync) + 4*SCAN_DIV + DEBOUNCE_CYC + 1 cycles.
- Latency, release to drop: 2 + DEBOUNCE_CYC + 1 cycles.
- Reset mid-operation: all outputs return to reset values immediately, regardless of state; no strobe is emitted.
- key and keypad_pressed change only on the same cycle transitions listed above. The consumer may sample them at the level (no pulse required), so key must never change while keypad_pressed=1.

Test Plan (bench with SCAN_DIV=4, DEBOUNCE_CYC=8; the bench models the matrix by pulling row r low whenever col_n[c]=0 and key (r,c) is pressed):
- Reset with no keys -> col_n cycles 1110,1101,1011,0111 every 4 clk; keypad_pressed=0; key=31; key_strobe never high.
- Hold key (2,2) cleanly -> keypad_pressed=1, key=10, one-cycle key_strobe; release -> keypad_pressed=0, key=31 exactly 11 cycles after the release edge.
- Press (3,1) with 3-cycle bounce pulses before stable -> no strobe during bounce; then key=13, exactly one strobe.
- Hold (3,3), bounce 2 cycles high during release -> keypad_pressed stays 1, key=15, no second strobe; final release drops after 8 stable cycles.
- Hold (1,2) and (3,2) together -> key=6; then release (1,2) while (3,2) is still held -> key=31 then re-detect, key=14.
- Assert rst while in HELD with key=14 -> same cycle keypad_pressed=0, key=31, col_n=1110; after rst falls, scanning resumes from column 0.

Source files
------------

// File: rtl/keypad_scanner.sv
// ---------------------------------------------------------------------------
// keypad_scanner
//
// Scans a 4x4 active-low matrix keypad one column at a time, debounces both
// the press and the release of a single key, and presents the result as a
// level interface (keypad_pressed + key) plus a one-cycle key_strobe on the
// press edge. The first key found wins; further keys are ignored until it is
// released.
//
// Parameters:
//   SCAN_DIV      clk cycles each column is driven; rows are sampled on the
//                 last cycle of that window (min 4).
//   DEBOUNCE_CYC  consecutive stable cycles needed to accept a press or a
//                 release (min 2).
//
// Ports:
//   clk             system clock
//   rst             asynchronous active-high reset
//   row_n[3:0]      keypad rows, active-low, asynchronous to clk
//   col_n[3:0]      keypad column drive, active-low, exactly one bit low
//   keypad_pressed  high while a debounced key is held
//   key[4:0]        4*row+col of the held key, 5'd31 when none
//   key_strobe      one-cycle pulse on the cycle keypad_pressed rises
// ---------------------------------------------------------------------------
module keypad_scanner #(
    parameter int unsigned SCAN_DIV     = 27000,
    parameter int unsigned DEBOUNCE_CYC = 540000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic       keypad_pressed,
    output logic [4:0] key,
    output logic       key_strobe
);

    localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYC + 1);

    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYC);
    localparam logic [4:0]        KEY_NONE  = 5'd31;

    typedef enum logic [1:0] {
        StScan,
        StDebounce,
        StHeld,
        StRelease
    } state_e;

    // ------------------------------------------------------------------
    // Row synchronizer
    // ------------------------------------------------------------------
    logic [3:0] sync_meta_d, sync_meta_q;
    logic [3:0] rows_s_d, rows_s_q;

    always_comb begin
        sync_meta_d = row_n;
        rows_s_d    = sync_meta_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta_q <= 4'b1111;
            rows_s_q    <= 4'b1111;
        end else begin
            sync_meta_q <= sync_meta_d;
            rows_s_q    <= rows_s_d;
        end
    end

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    state_e             state_d, state_q;
    logic [SCAN_W-1:0]  scan_cnt_d, scan_cnt_q;
    logic [DEB_W-1:0]   deb_cnt_d, deb_cnt_q;
    logic [1:0]         col_d, col_q;
    logic [1:0]         cand_row_d, cand_row_q;
    logic [1:0]         cand_col_d, cand_col_q;
    logic               pressed_d, pressed_q;
    logic [4:0]         key_d, key_q;
    logic               strobe_d, strobe_q;

    // Lowest-index low row; only meaningful when some row is low.
    logic [1:0] low_row;
    logic       any_low;
    logic       cand_low;
    logic [DEB_W-1:0] deb_inc;

    always_comb begin
        low_row = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows_s_q[i]) begin
                low_row = 2'(i);
            end
        end
    end

    always_comb begin
        any_low  = (rows_s_q != 4'b1111);
        cand_low = !rows_s_q[cand_row_q];
        deb_inc  = deb_cnt_q + DEB_W'(1);
    end

    // Next-state and output-register logic
    always_comb begin
        state_d    = state_q;
        scan_cnt_d = scan_cnt_q;
        deb_cnt_d  = deb_cnt_q;
        col_d      = col_q;
        cand_row_d = cand_row_q;
        cand_col_d = cand_col_q;
        pressed_d  = pressed_q;
        key_d      = key_q;
        strobe_d   = 1'b0;

        unique case (state_q)
            StScan: begin
                if (scan_cnt_q == SCAN_LAST) begin
                    scan_cnt_d = '0;
                    if (any_low) begin
                        // Column stays frozen on the candidate while debouncing.
                        cand_row_d = low_row;
                        cand_col_d = col_q;
                        deb_cnt_d  = '0;
                        state_d    = StDebounce;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    scan_cnt_d = scan_cnt_q + SCAN_W'(1);
                end
            end

            StDebounce: begin
                if (cand_low) begin
                    deb_cnt_d = deb_inc;
                    if (deb_inc == DEB_LAST) begin
                        pressed_d = 1'b1;
                        key_d     = {1'b0, cand_row_q, cand_col_q};
                        strobe_d  = 1'b1;
                        state_d   = StHeld;
                    end
                end else begin
                    // Bounce: give up and move on so a stuck column cannot starve the rest.
                    deb_cnt_d  = '0;
                    scan_cnt_d = '0;
                    col_d      = col_q + 2'd1;
                    state_d    = StScan;
                end
            end

            StHeld: begin
                if (!cand_low) begin
                    deb_cnt_d = '0;
                    state_d   = StRelease;
                end
            end

            StRelease: begin
                if (cand_low) begin
                    // Release bounce: still held, no new strobe.
                    deb_cnt_d = '0;
                    state_d   = StHeld;
                end else begin
                    deb_cnt_d = deb_inc;
                    if (deb_inc == DEB_LAST) begin
                        pressed_d  = 1'b0;
                        key_d      = KEY_NONE;
                        deb_cnt_d  = '0;
                        scan_cnt_d = '0;
                        col_d      = col_q + 2'd1;
                        state_d    = StScan;
                    end
                end
            end

            default: begin
                state_d = StScan;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StScan;
            scan_cnt_q <= '0;
            deb_cnt_q  <= '0;
            col_q      <= 2'd0;
            cand_row_q <= 2'd0;
            cand_col_q <= 2'd0;
            pressed_q  <= 1'b0;
            key_q      <= KEY_NONE;
            strobe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            scan_cnt_q <= scan_cnt_d;
            deb_cnt_q  <= deb_cnt_d;
            col_q      <= col_d;
            cand_row_q <= cand_row_d;
            cand_col_q <= cand_col_d;
            pressed_q  <= pressed_d;
            key_q      <= key_d;
            strobe_q   <= strobe_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        col_n        = 4'b1111;
        col_n[col_q] = 1'b0;
    end

    always_comb begin
        keypad_pressed = pressed_q;
        key            = key_q;
        key_strobe     = strobe_q;
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CYC=8.
// The keypad matrix is modelled by pulling row r low while col_n[c] is low
// and key (r,c) is pressed.
module tb_keypad_scanner;

    logic       clk;
    logic       rst;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic       keypad_pressed;
    logic [4:0] key;
    logic       key_strobe;

    // keys[r*4+c] set means key (r,c) is pressed
    logic [15:0] keys;

    int total;
    int bad;
    int strobe_cnt;
    int glitch_cnt;
    logic       pressed_prev;
    logic [4:0] key_prev;

    keypad_scanner #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CYC (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .row_n          (row_n),
        .col_n          (col_n),
        .keypad_pressed (keypad_pressed),
        .key            (key),
        .key_strobe     (key_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        row_n = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !col_n[c]) begin
                    row_n[r] = 1'b0;
                end
            end
        end
    end

    // Strobe counter and key-stability monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (key_strobe === 1'b1) begin
            strobe_cnt = strobe_cnt + 1;
        end
        if (pressed_prev === 1'b1 && keypad_pressed === 1'b1 && key !== key_prev) begin
            glitch_cnt = glitch_cnt + 1;
        end
        pressed_prev = keypad_pressed;
        key_prev     = key;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic wait_level(input logic lvl, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(posedge clk);
            #1;
            if (keypad_pressed === lvl) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_col;
        int         bad_lvl;
        rst  = 1'b1;
        keys = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (col_n !== 4'b1110) begin
            bad++; $display("FAIL reset_col_n: got %b want 1110", col_n);
        end
        total++;
        if (keypad_pressed !== 1'b0) begin
            bad++; $display("FAIL reset_pressed: got %b want 0", keypad_pressed);
        end
        total++;
        if (key !== 5'd31) begin
            bad++; $display("FAIL reset_key: got %0d want 31", key);
        end
        total++;
        if (key_strobe !== 1'b0) begin
            bad++; $display("FAIL reset_strobe: got %b want 0", key_strobe);
        end
        strobe_cnt = 0;
        rst        = 1'b0;
        bad_lvl    = 0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            exp_col = 4'b1111;
            exp_col[(k / 4) % 4] = 1'b0;
            total++;
            if (col_n !== exp_col) begin
                bad++; $display("FAIL idle_scan_col edge %0d: got %b want %b", k, col_n, exp_col);
            end
            if (keypad_pressed !== 1'b0 || key !== 5'd31) bad_lvl++;
        end
        total++;
        if (bad_lvl != 0) begin
            bad++; $display("FAIL idle_outputs: %0d bad cycles, want 0", bad_lvl);
        end
        total++;
        if (strobe_cnt != 0) begin
            bad++; $display("FAIL idle_strobe: got %0d strobes want 0", strobe_cnt);
        end
    endtask

    task automatic test_clean_press();
        bit ok;
        int early_drop;
        strobe_cnt = 0;
        keys[10]   = 1'b1;
        wait_level(1'b1, 100, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL clean_press_timeout: pressed=%b want 1", keypad_pressed);
        end
        total++;
        if (key !== 5'd10) begin
            bad++; $display("FAIL clean_key: got %0d want 10", key);
        end
        total++;
        if (key_strobe !== 1'b1) begin
            bad++; $display("FAIL clean_strobe_edge: got %b want 1", key_strobe);
        end
        @(posedge clk);
        #1;
        total++;
        if (key_strobe !== 1'b0) begin
            bad++; $display("FAIL clean_strobe_width: got %b want 0", key_strobe);
        end
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (strobe_cnt != 1) begin
            bad++; $display("FAIL clean_strobe_count: got %0d want 1", strobe_cnt);
        end
        // Release right after an edge; drop is due on the 11th edge after it.
        keys[10]   = 1'b0;
        early_drop = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (keypad_pressed !== 1'b1) early_drop++;
        end
        total++;
        if (early_drop != 0) begin
            bad++; $display("FAIL clean_release_early: %0d early cycles want 0", early_drop);
        end
        @(posedge clk);
        #1;
        total++;
        if (keypad_pressed !== 1'b0 || key !== 5'd31) begin
            bad++;
            $display("FAIL clean_release_edge11: pressed=%b key=%0d want 0/31", keypad_pressed, key);
        end
    endtask

    task automatic test_bounce_press();
        bit ok;
        strobe_cnt = 0;
        for (int p = 0; p < 3; p++) begin
            keys[13] = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            keys[13] = 1'b0;
            repeat (3) @(posedge clk);
            #1;
        end
        total++;
        if (keypad_pressed !== 1'b0 || strobe_cnt != 0) begin
            bad++;
            $display("FAIL bounce_no_press: pressed=%b strobes=%0d want 0/0", keypad_pressed,
                     strobe_cnt);
        end
        keys[13] = 1'b1;
        wait_level(1'b1, 100, ok);
        total++;
        if (!ok || key !== 5'd13) begin
            bad++; $display("FAIL bounce_key: ok=%0d key=%0d want 1/13", ok, key);
        end
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (strobe_cnt != 1) begin
            bad++; $display("FAIL bounce_strobe_count: got %0d want 1", strobe_cnt);
        end
        keys[13] = 1'b0;
        wait_level(1'b0, 40, ok);
        total++;
        if (!ok || key !== 5'd31) begin
            bad++; $display("FAIL bounce_release: ok=%0d key=%0d want 1/31", ok, key);
        end
    endtask

    task automatic test_release_bounce();
        bit ok;
        int drops;
        strobe_cnt = 0;
        keys[15]   = 1'b1;
        wait_level(1'b1, 100, ok);
        total++;
        if (!ok || key !== 5'd15) begin
            bad++; $display("FAIL rb_press: ok=%0d key=%0d want 1/15", ok, key);
        end
        keys[15] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        keys[15] = 1'b1;
        drops    = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (keypad_pressed !== 1'b1 || key !== 5'd15) drops++;
        end
        total++;
        if (drops != 0) begin
            bad++; $display("FAIL rb_held_through_bounce: %0d bad cycles want 0", drops);
        end
        total++;
        if (strobe_cnt != 1) begin
            bad++; $display("FAIL rb_strobe_count: got %0d want 1", strobe_cnt);
        end
        keys[15] = 1'b0;
        drops    = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (keypad_pressed !== 1'b1) drops++;
        end
        total++;
        if (drops != 0) begin
            bad++; $display("FAIL rb_release_early: %0d early cycles want 0", drops);
        end
        @(posedge clk);
        #1;
        total++;
        if (keypad_pressed !== 1'b0 || key !== 5'd31) begin
            bad++;
            $display("FAIL rb_release_edge11: pressed=%b key=%0d want 0/31", keypad_pressed, key);
        end
    endtask

    task automatic test_same_column();
        bit ok;
        strobe_cnt = 0;
        keys[6]    = 1'b1;
        keys[14]   = 1'b1;
        wait_level(1'b1, 100, ok);
        total++;
        if (!ok || key !== 5'd6) begin
            bad++; $display("FAIL col_pair_key: ok=%0d key=%0d want 1/6", ok, key);
        end
        @(posedge clk);
        #1;
        keys[6] = 1'b0;
        wait_level(1'b0, 40, ok);
        total++;
        if (!ok || key !== 5'd31) begin
            bad++; $display("FAIL col_pair_release: ok=%0d key=%0d want 1/31", ok, key);
        end
        wait_level(1'b1, 100, ok);
        total++;
        if (!ok || key !== 5'd14) begin
            bad++; $display("FAIL col_pair_redetect: ok=%0d key=%0d want 1/14", ok, key);
        end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (strobe_cnt != 2) begin
            bad++; $display("FAIL col_pair_strobes: got %0d want 2", strobe_cnt);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] exp_col;
        @(posedge clk);
        #1;
        total++;
        if (keypad_pressed !== 1'b1 || key !== 5'd14) begin
            bad++;
            $display("FAIL mid_precond: pressed=%b key=%0d want 1/14", keypad_pressed, key);
        end
        strobe_cnt = 0;
        rst        = 1'b1;
        #1;
        total++;
        if (keypad_pressed !== 1'b0 || key !== 5'd31 || col_n !== 4'b1110 || key_strobe !== 1'b0)
        begin
            bad++;
            $display("FAIL mid_reset: pressed=%b key=%0d col_n=%b strobe=%b want 0/31/1110/0",
                     keypad_pressed, key, col_n, key_strobe);
        end
        keys = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            exp_col = 4'b1111;
            exp_col[(k / 4) % 4] = 1'b0;
            total++;
            if (col_n !== exp_col) begin
                bad++; $display("FAIL mid_resume_col edge %0d: got %b want %b", k, col_n, exp_col);
            end
        end
        total++;
        if (strobe_cnt != 0 || keypad_pressed !== 1'b0) begin
            bad++;
            $display("FAIL mid_after: strobes=%0d pressed=%b want 0/0", strobe_cnt, keypad_pressed);
        end
    endtask

    task automatic test_key_stable();
        total++;
        if (glitch_cnt != 0) begin
            bad++; $display("FAIL key_stable: %0d key changes while pressed, want 0", glitch_cnt);
        end
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        strobe_cnt   = 0;
        glitch_cnt   = 0;
        pressed_prev = 1'b0;
        key_prev     = 5'd31;
        keys         = '0;
        rst          = 1'b1;
        test_reset();
        test_clean_press();
        test_bounce_press();
        test_release_bounce();
        test_same_column();
        test_reset_mid();
        test_key_stable();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
